// File: rtl/gtfraw_drp_pkg.sv
// Shared widths, FSM encoding and counter sizes for the GTF raw DRP
// register responder.
package gtfraw_drp_pkg;

    localparam int DRP_ADDR_W_DEF = 9;
    localparam int DRP_DATA_W_DEF = 16;
    localparam int LAT_CNT_W      = 4;
    localparam int ERR_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } drp_state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_add(
        input logic [ERR_CNT_W-1:0] base,
        input logic [1:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, base} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/gtfraw_drp_reg_responder.sv
// DRP slave backing a soft register bank with programmable read/write latency.
// Define GTFRAW_DRP_RESP_NORDY_EN to suppress drp_rdy on out-of-range accesses.
module gtfraw_drp_reg_responder
    import gtfraw_drp_pkg::*;
#(
    parameter int DRP_ADDR_WIDTH = DRP_ADDR_W_DEF,
    parameter int DRP_DATA_WIDTH = DRP_DATA_W_DEF,
    parameter int NUM_REGS       = 32,
    parameter int RD_LATENCY     = 2,
    parameter int WR_LATENCY     = 3,
    parameter logic [DRP_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_aresetn,
    input  logic                               drp_en,
    input  logic                               drp_we,
    input  logic [DRP_ADDR_WIDTH-1:0]          drp_addr,
    input  logic [DRP_DATA_WIDTH-1:0]          drp_di,
    output logic [DRP_DATA_WIDTH-1:0]          drp_do,
    output logic                               drp_rdy,
    output logic [NUM_REGS*DRP_DATA_WIDTH-1:0] reg_q,
    input  logic                               hw_wr_en,
    input  logic [DRP_ADDR_WIDTH-1:0]          hw_wr_addr,
    input  logic [DRP_DATA_WIDTH-1:0]          hw_wr_data,
    output logic                               proto_err,
    output logic                               range_err,
    output logic [ERR_CNT_W-1:0]               err_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DRP_ADDR_WIDTH:0] NREGS =
        (DRP_ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [LAT_CNT_W-1:0] RD_CNT = LAT_CNT_W'(RD_LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] WR_CNT = LAT_CNT_W'(WR_LATENCY - 1);

    drp_state_e state;
    drp_state_e state_nxt;

    logic [LAT_CNT_W-1:0]      cnt;
    logic [LAT_CNT_W-1:0]      cnt_nxt;
    logic [LAT_CNT_W-1:0]      lat_load;
    logic                      lat_we;
    logic [DRP_ADDR_WIDTH-1:0] lat_addr;
    logic [DRP_DATA_WIDTH-1:0] lat_di;

    logic [DRP_DATA_WIDTH-1:0] mem [NUM_REGS];

    logic             accept;
    logic             resp;
    logic             acc_ok;
    logic             drp_wr;
    logic             hw_ok;
    logic [IDX_W-1:0] drp_idx;
    logic [IDX_W-1:0] hw_idx;

    function automatic logic in_range(input logic [DRP_ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_load  = drp_we ? WR_CNT : RD_CNT;
        unique case (state)
            IDLE: begin
                if (drp_en) begin
                    cnt_nxt   = lat_load;
                    state_nxt = (lat_load == '0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt_nxt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign accept = drp_en && (state == IDLE);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_di   <= '0;
        end else if (accept) begin
            lat_we   <= drp_we;
            lat_addr <= drp_addr;
            lat_di   <= drp_di;
        end
    end

    assign resp    = (state == RESP);
    assign acc_ok  = in_range(lat_addr);
    assign drp_idx = lat_addr[IDX_W-1:0];
    assign hw_idx  = hw_wr_addr[IDX_W-1:0];
    assign drp_wr  = resp && lat_we && acc_ok;

    // A DRP write completing on the same register takes precedence.
    assign hw_ok = hw_wr_en && in_range(hw_wr_addr) &&
                   !(drp_wr && (hw_wr_addr == lat_addr));

`ifdef GTFRAW_DRP_RESP_NORDY_EN
    assign drp_rdy = resp && acc_ok;
`else
    assign drp_rdy = resp;
`endif

    assign drp_do    = (drp_rdy && !lat_we && acc_ok) ? mem[drp_idx] : '0;
    assign range_err = resp && !acc_ok;
    assign proto_err = drp_en && (state != IDLE);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= RESET_VAL;
            end
        end else begin
            if (hw_ok) begin
                mem[hw_idx] <= hw_wr_data;
            end
            if (drp_wr) begin
                mem[drp_idx] <= lat_di;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            err_count <= '0;
        end else begin
            err_count <= sat_add(err_count,
                                 {1'b0, proto_err} + {1'b0, range_err});
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
        assign reg_q[k*DRP_DATA_WIDTH +: DRP_DATA_WIDTH] = mem[k];
    end

endmodule
